// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: shares the IMEM fetch port between core and debug
// readers, with range/alignment pre-check and a bounded fetch window.
module imem_fetch_ctrl #(
  parameter logic [31:0] IMEM_BASE = 32'h0100_0000,
  parameter int unsigned IMEM_SIZE = 2048,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic [31:0] core_addr,
  output logic        core_ack,
  output logic [31:0] core_instr,
  output logic        core_fault,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_ack,
  output logic [31:0] dbg_data,
  output logic        dbg_fault,
  output logic        instrfetch,
  output logic [31:0] addr_imem,
  input  logic [31:0] instr,
  input  logic        instr_fetched
);

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SIZE = 32'(IMEM_SIZE);
  localparam logic [7:0]  TO   = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    DRAIN
  } state_t;

  state_t      state_q;
  logic        last_dbg_q;
  logic        gnt_dbg_q;
  logic [7:0]  cnt_q;
  logic        fetch_q;
  logic [31:0] addr_q;

  logic        core_ack_q;
  logic        core_fault_q;
  logic [31:0] core_data_q;
  logic        dbg_ack_q;
  logic        dbg_fault_q;
  logic [31:0] dbg_data_q;

  logic        any_req;
  logic        pick_dbg;
  logic [31:0] sel_addr;
  logic [31:0] offs;
  logic        sel_ok;

  logic        rsp_en;
  logic        rsp_dbg;
  logic        rsp_fault;
  logic [31:0] rsp_data;

  // Choose the requester for this IDLE cycle and classify its address.
  always_comb begin
    any_req  = core_req | dbg_req;
    pick_dbg = dbg_req & (~core_req | ~last_dbg_q);
    sel_addr = pick_dbg ? dbg_addr : core_addr;
    offs     = sel_addr - IMEM_BASE;
    sel_ok   = (sel_addr >= IMEM_BASE)
             & (offs < SIZE)
             & (sel_addr[1:0] == 2'b00);
  end

  // Decide whether a response is issued at this edge and what it carries.
  always_comb begin
    rsp_en    = 1'b0;
    rsp_dbg   = gnt_dbg_q;
    rsp_fault = 1'b0;
    rsp_data  = NOP;
    unique case (state_q)
      IDLE: begin
        if (any_req && !sel_ok) begin
          rsp_en    = 1'b1;
          rsp_dbg   = pick_dbg;
          rsp_fault = 1'b1;
        end
      end
      ISSUE: begin
        if (instr_fetched) begin
          rsp_en   = 1'b1;
          rsp_data = instr;
        end else if (cnt_q == TO) begin
          rsp_en    = 1'b1;
          rsp_fault = 1'b1;
        end
      end
      default: begin
        rsp_en = 1'b0;
      end
    endcase
  end

  // Sequencer: arbitration, IMEM handshake and registered port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_dbg_q   <= 1'b1;
      gnt_dbg_q    <= 1'b0;
      cnt_q        <= '0;
      fetch_q      <= 1'b0;
      addr_q       <= '0;
      core_ack_q   <= 1'b0;
      core_fault_q <= 1'b0;
      core_data_q  <= '0;
      dbg_ack_q    <= 1'b0;
      dbg_fault_q  <= 1'b0;
      dbg_data_q   <= '0;
    end else begin
      core_ack_q <= 1'b0;
      dbg_ack_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_dbg_q <= pick_dbg;
            if (core_req && dbg_req) begin
              last_dbg_q <= pick_dbg;
            end
            if (sel_ok) begin
              addr_q  <= sel_addr;
              fetch_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= ISSUE;
            end else begin
              state_q <= RESP;
            end
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + 8'd1;
          if (rsp_en) begin
            fetch_q <= 1'b0;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= DRAIN;
        end
        DRAIN: begin
          if (!instr_fetched) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      if (rsp_en) begin
        if (rsp_dbg) begin
          dbg_ack_q   <= 1'b1;
          dbg_data_q  <= rsp_data;
          dbg_fault_q <= rsp_fault;
        end else begin
          core_ack_q   <= 1'b1;
          core_data_q  <= rsp_data;
          core_fault_q <= rsp_fault;
        end
      end
    end
  end

  assign instrfetch = fetch_q;
  assign addr_imem  = addr_q;
  assign core_ack   = core_ack_q;
  assign core_instr = core_data_q;
  assign core_fault = core_fault_q;
  assign dbg_ack    = dbg_ack_q;
  assign dbg_data   = dbg_data_q;
  assign dbg_fault  = dbg_fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed and random stimulus for imem_fetch_ctrl,
// checked every cycle against a transaction-timing reference model.
module tb_imem_fetch_ctrl;

  localparam int          T    = 4;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0;
  logic        dbg_req = 1'b0;
  logic [31:0] core_addr = BASE;
  logic [31:0] dbg_addr = BASE;
  logic        core_ack, core_fault;
  logic        dbg_ack, dbg_fault;
  logic        instrfetch;
  logic [31:0] core_instr, dbg_data, addr_imem;
  logic [31:0] instr = '0;
  logic        instr_fetched = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] mem [512];

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  imem_fetch_ctrl #(
    .IMEM_BASE(BASE),
    .IMEM_SIZE(2048),
    .TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .core_req(core_req),
    .core_addr(core_addr),
    .core_ack(core_ack),
    .core_instr(core_instr),
    .core_fault(core_fault),
    .dbg_req(dbg_req),
    .dbg_addr(dbg_addr),
    .dbg_ack(dbg_ack),
    .dbg_data(dbg_data),
    .dbg_fault(dbg_fault),
    .instrfetch(instrfetch),
    .addr_imem(addr_imem),
    .instr(instr),
    .instr_fetched(instr_fetched)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE)
        && (a <= BASE + 32'h7FC);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // IMEM responder: data-valid one cycle after a sampled fetch.
  always @(posedge clk) begin
    instr_fetched <= instrfetch && legal(addr_imem) && !stall;
    instr         <= mem[addr_imem[10:2]];
  end

  // Reference model: one access at a time, timing from the access class.
  int          cyc = 0;
  bit          pend = 0, pdbg = 0, pfetch = 0, pfault = 0;
  int          ack_at = 0, fetch_end = 0, free_at = 0, lat_m = 0;
  logic [31:0] paddr = '0, pdata = '0;
  bit          last_dbg = 1;
  bit          e_core_ack = 0, e_dbg_ack = 0, e_fetch = 0;
  bit          e_core_f = 0, e_dbg_f = 0;
  logic [31:0] e_core_d = '0, e_dbg_d = '0, e_addr = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
    e_core_ack = 0;
    e_dbg_ack  = 0;
    if (rst) begin
      pend     = 0;
      free_at  = cyc + 1;
      last_dbg = 1;
      e_core_d = '0;
      e_dbg_d  = '0;
      e_core_f = 0;
      e_dbg_f  = 0;
      e_addr   = '0;
    end else begin
      if (!pend && cyc >= free_at && (core_req || dbg_req)) begin
        if (core_req && dbg_req) begin
          pdbg     = !last_dbg;
          last_dbg = pdbg;
        end else begin
          pdbg = dbg_req;
        end
        paddr = pdbg ? dbg_addr : core_addr;
        if (!legal(paddr)) begin
          lat_m = 1; pfetch = 0; pfault = 1; pdata = NOP;
        end else if (stall) begin
          lat_m = T + 2; pfetch = 1; pfault = 1; pdata = NOP;
        end else begin
          lat_m = 3; pfetch = 1; pfault = 0;
          pdata = mem[paddr[10:2]];
        end
        if (pfetch) e_addr = paddr;
        ack_at    = cyc + lat_m - 1;
        fetch_end = cyc + lat_m - 2;
        free_at   = cyc + lat_m + 2;
        pend      = 1;
      end
      if (pend && cyc == ack_at) begin
        if (pdbg) begin
          e_dbg_ack = 1; e_dbg_d = pdata; e_dbg_f = pfault;
        end else begin
          e_core_ack = 1; e_core_d = pdata; e_core_f = pfault;
        end
        pend = 0;
      end
    end
    e_fetch = pend && pfetch && (cyc <= fetch_end);
  end

  // Per-cycle comparison of every DUT output against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("core_ack", 32'(core_ack), 32'(e_core_ack));
      chk("dbg_ack", 32'(dbg_ack), 32'(e_dbg_ack));
      chk("core_instr", core_instr, e_core_d);
      chk("dbg_data", dbg_data, e_dbg_d);
      chk("instrfetch", 32'(instrfetch), 32'(e_fetch));
      chk("addr_imem", addr_imem, e_addr);
      if (e_core_ack) chk("core_fault", 32'(core_fault), 32'(e_core_f));
      if (e_dbg_ack) chk("dbg_fault", 32'(dbg_fault), 32'(e_dbg_f));
    end
  end

  function automatic logic [31:0] rnd_addr();
    int unsigned k;
    logic [31:0] a;
    k = $urandom_range(9);
    if (k == 0) a = BASE + 32'h800 + 32'($urandom_range(255) << 2);
    else if (k == 1) a = BASE - 32'(($urandom_range(63) + 1) << 2);
    else if (k == 2) a = BASE + 32'($urandom_range(2047));
    else if (k == 3) a = BASE + 32'h7FC;
    else if (k == 4) a = BASE + 32'h800;
    else a = BASE + 32'($urandom_range(511) << 2);
    return a;
  endfunction

  // Present one request and wait (bounded) for its acknowledge.
  task automatic single(input bit dbg, input logic [31:0] a,
                        output int lat, output logic [31:0] d,
                        output logic f, output int nf);
    if (dbg) begin dbg_addr = a; dbg_req = 1; end
    else begin core_addr = a; core_req = 1; end
    lat = -1; nf = 0; d = '0; f = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      nf += int'(instrfetch);
      if (dbg ? dbg_ack : core_ack) begin
        lat = i;
        d = dbg ? dbg_data : core_instr;
        f = dbg ? dbg_fault : core_fault;
        break;
      end
    end
    if (dbg) dbg_req = 0;
    else core_req = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_phase(input int n, input bit rsts);
    for (int i = 0; i < n + 60; i++) begin
      @(negedge clk);
      rst = 1'b0;
      if (core_req && core_ack) core_req = 0;
      if (dbg_req && dbg_ack) dbg_req = 0;
      if (i < n) begin
        if (!core_req && $urandom_range(2) == 0) begin
          core_req = 1; core_addr = rnd_addr();
        end
        if (!dbg_req && $urandom_range(2) == 0) begin
          dbg_req = 1; dbg_addr = rnd_addr();
        end
        if (rsts && $urandom_range(40) == 0) rst = 1'b1;
      end
    end
    chk("quiet", 32'(core_req | dbg_req), 32'd0);
    core_req = 0;
    dbg_req = 0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, nf, ng, nc, nd, last_t;
    logic [31:0] d;
    logic        f;
    bit          pc, pd;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[1]   = 32'h0020_0093;
    mem[3]   = 32'h0000_0513;
    mem[4]   = 32'h0041_0113;
    mem[511] = 32'h7FC0_0513;

    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_instrfetch", 32'(instrfetch), 32'd0);
    chk("rst_core_ack", 32'(core_ack), 32'd0);
    chk("rst_core_instr", core_instr, 32'd0);
    chk("rst_addr_imem", addr_imem, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    single(0, BASE + 32'h4, lat, d, f, nf);
    chk("legal_lat", 32'(lat), 32'd3);
    chk("legal_data", d, 32'h0020_0093);
    chk("legal_fault", 32'(f), 32'd0);
    chk("legal_fetch_cycles", 32'(nf), 32'd2);

    single(0, BASE + 32'h800, lat, d, f, nf);
    chk("range_lat", 32'(lat), 32'd1);
    chk("range_data", d, NOP);
    chk("range_fault", 32'(f), 32'd1);
    chk("range_nofetch", 32'(nf), 32'd0);

    single(0, BASE + 32'h6, lat, d, f, nf);
    chk("align_lat", 32'(lat), 32'd1);
    chk("align_data", d, NOP);
    chk("align_fault", 32'(f), 32'd1);
    chk("align_nofetch", 32'(nf), 32'd0);

    core_addr = BASE + 32'h20;
    dbg_addr  = BASE + 32'h40;
    core_req = 1; dbg_req = 1;
    ng = 0; nc = 0; nd = 0; last_t = 0; pc = 0; pd = 0;
    for (int i = 0; i < 120 && ng < 6; i++) begin
      @(negedge clk);
      if (pc) chk("arb_core_pulse", 32'(core_ack), 32'd0);
      if (pd) chk("arb_dbg_pulse", 32'(dbg_ack), 32'd0);
      pc = core_ack;
      pd = dbg_ack;
      if (core_ack || dbg_ack) begin
        chk("arb_order", 32'(dbg_ack), 32'(ng % 2));
        if (ng > 0) chk("arb_gap_ge5", 32'((i - last_t) >= 5), 32'd1);
        last_t = i;
        ng++;
        if (core_ack) begin
          nc++; core_req = (nc < 3); core_addr += 4;
        end
        if (dbg_ack) begin
          nd++; dbg_req = (nd < 3); dbg_addr += 4;
        end
      end
    end
    chk("arb_grants", 32'(ng), 32'd6);
    core_req = 0; dbg_req = 0;
    @(negedge clk);
    if (pc) chk("arb_core_pulse", 32'(core_ack), 32'd0);
    if (pd) chk("arb_dbg_pulse", 32'(dbg_ack), 32'd0);
    repeat (3) @(negedge clk);

    stall = 1'b1;
    single(0, BASE + 32'h8, lat, d, f, nf);
    chk("tmo_lat", 32'(lat), 32'(T + 2));
    chk("tmo_data", d, NOP);
    chk("tmo_fault", 32'(f), 32'd1);
    chk("tmo_fetch_cycles", 32'(nf), 32'(T + 1));
    stall = 1'b0;
    single(0, BASE + 32'hC, lat, d, f, nf);
    chk("after_tmo_lat", 32'(lat), 32'd3);
    chk("after_tmo_data", d, 32'h0000_0513);
    chk("after_tmo_fault", 32'(f), 32'd0);

    core_addr = BASE + 32'h10;
    core_req = 1;
    @(negedge clk);
    chk("issue_before_rst", 32'(instrfetch), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drop_fetch", 32'(instrfetch), 32'd0);
    chk("rst_no_ack", 32'(core_ack), 32'd0);
    rst = 1'b0;
    single(0, BASE + 32'h10, lat, d, f, nf);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_data", d, 32'h0041_0113);

    single(1, BASE + 32'h7FC, lat, d, f, nf);
    chk("last_word_lat", 32'(lat), 32'd3);
    chk("last_word_data", d, 32'h7FC0_0513);
    chk("last_word_fault", 32'(f), 32'd0);

    rand_phase(500, 1'b0);
    stall = 1'b1;
    rand_phase(200, 1'b0);
    stall = 1'b0;
    rand_phase(500, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
